// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage operand forwarding, writeback hold buffer and load-use/slow-memory stall control
// Optional: define FWD_STALL_CNT_EN to add the stall_cycles counter output.
module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic [REG_W-1:0]  id_ex_rs,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              id_ex_memread,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [REG_W-1:0]  mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [DATA_W-1:0] mem_wb_result,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_idex,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              mem_timeout
);

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b10;
  localparam logic [1:0] SEL_MWB  = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b11;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUBBLE, MEM_WAIT} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                cnt_clr, cnt_inc, timeout_set, stall;
  logic                load_use;
  logic                hold_valid;
  logic [REG_W-1:0]    hold_rd;
  logic [DATA_W-1:0]   hold_val;

  // Priority: youngest producer wins; register 0 is never forwarded.
  function automatic logic [1:0] pick_sel(input logic [REG_W-1:0] src);
    if (src == '0)
      pick_sel = SEL_RF;
    else if (ex_mem_regwrite && ex_mem_rd == src)
      pick_sel = SEL_EXM;
    else if (mem_wb_regwrite && mem_wb_rd == src)
      pick_sel = SEL_MWB;
    else if (hold_valid && hold_rd == src)
      pick_sel = SEL_HOLD;
    else
      pick_sel = SEL_RF;
  endfunction

  always_comb begin
    sel_a = pick_sel(id_ex_rs);
    sel_b = pick_sel(id_ex_rt);
  end

  always_comb begin
    op_a = rf_a;
    case (sel_a)
      SEL_EXM:  op_a = ex_mem_result;
      SEL_MWB:  op_a = mem_wb_result;
      SEL_HOLD: op_a = hold_val;
      default:  op_a = rf_a;
    endcase
  end

  always_comb begin
    op_b = rf_b;
    case (sel_b)
      SEL_EXM:  op_b = ex_mem_result;
      SEL_MWB:  op_b = mem_wb_result;
      SEL_HOLD: op_b = hold_val;
      default:  op_b = rf_b;
    endcase
  end

  // Keeps the last retired write so an instruction three behind still sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_val   <= '0;
    end else if (mem_wb_regwrite && mem_wb_rd != '0) begin
      hold_valid <= 1'b1;
      hold_rd    <= mem_wb_rd;
      hold_val   <= mem_wb_result;
    end
  end

  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (load_use) begin
          stall     = 1'b1;
          state_nxt = BUBBLE;
        end
      end
      BUBBLE: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end else begin
          stall     = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timeout_set = 1'b1;
          state_nxt   = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_pc   = stall;
  assign stall_ifid = stall;
  assign flush_idex = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        wait_cnt <= '0;
      else if (cnt_inc)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_set)
        mem_timeout <= 1'b1;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
